// File: rtl/forward_pkg.sv
// Shared types for the EX-stage forwarding unit.
// Select encoding for the ALU operand muxes.
package forward_pkg;

   localparam int FWD_REG_AW = 5;

   typedef enum logic [1:0] {
      FWD_RF = 2'b00,
      FWD_WB = 2'b01,
      FWD_EX = 2'b10
   } fwd_sel_t;

endpackage

// File: rtl/fwd_sel_one.sv
// One operand-select decoder: compares a source register
// against the EX/MEM and MEM/WB destinations.
module fwd_sel_one
   import forward_pkg::*;
#(
   parameter int AW = FWD_REG_AW
) (
   input  logic [AW-1:0] src,
   input  logic [AW-1:0] rd_ex,
   input  logic          ex_we,
   input  logic [AW-1:0] rd_wb,
   input  logic          wb_we,
   output fwd_sel_t      sel
);

   logic ex_hit;
   logic wb_hit;
   logic wb_only;

   // x0 is hard-wired zero, so a write to it is never forwarded
   assign ex_hit  = ex_we && (rd_ex != '0) && (rd_ex == src);
   assign wb_hit  = wb_we && (rd_wb != '0) && (rd_wb == src);
   assign wb_only = wb_hit && !ex_hit;

   // newer EX/MEM result wins over MEM/WB
   always_comb begin
      sel = FWD_RF;
      unique case (1'b1)
         ex_hit:  sel = FWD_EX;
         wb_only: sel = FWD_WB;
         default: sel = FWD_RF;
      endcase
   end

endmodule

// File: rtl/forward_unit.sv
// EX-stage data-hazard forwarding unit with debug snapshot.
// FWD_STATS_EN adds saturating forwarding statistics counters.
module forward_unit
   import forward_pkg::*;
#(
   parameter int REG_AW = FWD_REG_AW
`ifdef FWD_STATS_EN
   ,parameter int CNT_W = 32
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] Registro1,
   input  logic [REG_AW-1:0] Registro2,
   input  logic [REG_AW-1:0] Rd_execute,
   input  logic [REG_AW-1:0] Rd_writeback,
   input  logic              ex_regwrite,
   input  logic              wb_regwrite,
   output logic [1:0]        forwardA,
   output logic [1:0]        forwardB,
   output logic [1:0]        fwd_a_q,
   output logic [1:0]        fwd_b_q
`ifdef FWD_STATS_EN
   ,output logic [CNT_W-1:0] cnt_ex_fwd
   ,output logic [CNT_W-1:0] cnt_wb_fwd
   ,output logic [CNT_W-1:0] cnt_x0_block
`endif
);

   fwd_sel_t sel_a;
   fwd_sel_t sel_b;

   fwd_sel_one #(.AW(REG_AW)) u_sel_a (
      .src   (Registro1),
      .rd_ex (Rd_execute),
      .ex_we (ex_regwrite),
      .rd_wb (Rd_writeback),
      .wb_we (wb_regwrite),
      .sel   (sel_a)
   );

   fwd_sel_one #(.AW(REG_AW)) u_sel_b (
      .src   (Registro2),
      .rd_ex (Rd_execute),
      .ex_we (ex_regwrite),
      .rd_wb (Rd_writeback),
      .wb_we (wb_regwrite),
      .sel   (sel_b)
   );

   assign forwardA = sel_a;
   assign forwardB = sel_b;

   logic [1:0] fwd_a_d;
   logic [1:0] fwd_b_d;

   // next debug snapshot, cleared while in reset
   always_comb begin
      fwd_a_d = 2'b00;
      fwd_b_d = 2'b00;
      if (rst_n) begin
         fwd_a_d = forwardA;
         fwd_b_d = forwardB;
      end
   end

   // debug snapshot registers
   always_ff @(posedge clk) begin
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
   end

`ifdef FWD_STATS_EN
   logic [CNT_W-1:0] cnt_ex_fwd_q, cnt_ex_fwd_d;
   logic [CNT_W-1:0] cnt_wb_fwd_q, cnt_wb_fwd_d;
   logic [CNT_W-1:0] cnt_x0_q, cnt_x0_d;
   logic [1:0]       n_ex;
   logic [1:0]       n_wb;
   logic             x0_hit;
   logic [CNT_W:0]   sum_ex;
   logic [CNT_W:0]   sum_wb;
   logic [CNT_W:0]   sum_x0;

   assign n_ex = {1'b0, sel_a == FWD_EX}
               + {1'b0, sel_b == FWD_EX};
   assign n_wb = {1'b0, sel_a == FWD_WB}
               + {1'b0, sel_b == FWD_WB};

   // an enabled write to x0 that a source would have matched
   assign x0_hit =
      (ex_regwrite && (Rd_execute == '0) &&
       ((Registro1 == '0) || (Registro2 == '0))) ||
      (wb_regwrite && (Rd_writeback == '0) &&
       ((Registro1 == '0) || (Registro2 == '0)));

   assign sum_ex = {1'b0, cnt_ex_fwd_q}
                 + {{(CNT_W-1){1'b0}}, n_ex};
   assign sum_wb = {1'b0, cnt_wb_fwd_q}
                 + {{(CNT_W-1){1'b0}}, n_wb};
   assign sum_x0 = {1'b0, cnt_x0_q}
                 + {{CNT_W{1'b0}}, x0_hit};

   // saturating next-count, cleared while in reset
   always_comb begin
      cnt_ex_fwd_d = '0;
      cnt_wb_fwd_d = '0;
      cnt_x0_d     = '0;
      if (rst_n) begin
         cnt_ex_fwd_d = sum_ex[CNT_W] ? '1 : sum_ex[CNT_W-1:0];
         cnt_wb_fwd_d = sum_wb[CNT_W] ? '1 : sum_wb[CNT_W-1:0];
         cnt_x0_d     = sum_x0[CNT_W] ? '1 : sum_x0[CNT_W-1:0];
      end
   end

   // statistics counter registers
   always_ff @(posedge clk) begin
      cnt_ex_fwd_q <= cnt_ex_fwd_d;
      cnt_wb_fwd_q <= cnt_wb_fwd_d;
      cnt_x0_q     <= cnt_x0_d;
   end

   assign cnt_ex_fwd   = cnt_ex_fwd_q;
   assign cnt_wb_fwd   = cnt_wb_fwd_q;
   assign cnt_x0_block = cnt_x0_q;
`endif

endmodule

// File: tb/tb_forward_unit.sv
// Scoreboard bench for forward_unit: a driver pushes expected
// selects per cycle, a monitor pops and compares at negedge.
module tb_forward_unit;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] r1, r2, rd_ex, rd_wb;
   logic       ex_we, wb_we;
   logic [1:0] fa, fb, fa_q, fb_q;

   forward_unit dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .Registro1    (r1),
      .Registro2    (r2),
      .Rd_execute   (rd_ex),
      .Rd_writeback (rd_wb),
      .ex_regwrite  (ex_we),
      .wb_regwrite  (wb_we),
      .forwardA     (fa),
      .forwardB     (fb),
      .fwd_a_q      (fa_q),
      .fwd_b_q      (fb_q)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       exw;
      logic       wbw;
      logic [4:0] rde;
      logic [4:0] rdw;
      logic [4:0] s1;
      logic [4:0] s2;
      logic [1:0] ea;
      logic [1:0] eb;
   } vec_t;

   typedef struct {
      int         idx;
      logic [1:0] ea;
      logic [1:0] eb;
      logic       chk_q;
      logic [1:0] eqa;
      logic [1:0] eqb;
   } exp_t;

   vec_t vecs[18];
   exp_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   function automatic vec_t mk(
      input logic rst, input logic exw, input logic wbw,
      input int rde, input int rdw, input int s1, input int s2,
      input logic [1:0] ea, input logic [1:0] eb);
      vec_t v;
      v.rst = rst; v.exw = exw; v.wbw = wbw;
      v.rde = 5'(rde); v.rdw = 5'(rdw);
      v.s1 = 5'(s1); v.s2 = 5'(s2);
      v.ea = ea; v.eb = eb;
      return v;
   endfunction

   initial begin
      vecs[0]  = mk(0, 0, 0, 1, 2, 3, 4, 2'b00, 2'b00);
      vecs[1]  = mk(0, 1, 0, 3, 2, 3, 4, 2'b10, 2'b00);
      vecs[2]  = mk(1, 0, 0, 1, 2, 3, 4, 2'b00, 2'b00);
      vecs[3]  = mk(1, 1, 0, 3, 2, 3, 4, 2'b10, 2'b00);
      vecs[4]  = mk(1, 0, 1, 1, 3, 3, 4, 2'b01, 2'b00);
      vecs[5]  = mk(1, 1, 0, 4, 3, 3, 4, 2'b00, 2'b10);
      vecs[6]  = mk(1, 0, 1, 1, 4, 3, 4, 2'b00, 2'b01);
      vecs[7]  = mk(1, 1, 1, 4, 3, 3, 4, 2'b01, 2'b10);
      vecs[8]  = mk(1, 1, 1, 3, 3, 3, 4, 2'b10, 2'b00);
      vecs[9]  = mk(1, 1, 1, 0, 3, 0, 4, 2'b00, 2'b00);
      vecs[10] = mk(1, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00);
      vecs[11] = mk(1, 0, 0, 5, 5, 5, 5, 2'b00, 2'b00);
      vecs[12] = mk(1, 1, 1, 7, 7, 7, 7, 2'b10, 2'b10);
      vecs[13] = mk(1, 0, 1, 9, 7, 7, 7, 2'b01, 2'b01);
      vecs[14] = mk(0, 0, 1, 31, 31, 31, 31, 2'b01, 2'b01);
      vecs[15] = mk(1, 0, 0, 1, 2, 3, 4, 2'b00, 2'b00);
      vecs[16] = mk(1, 1, 1, 31, 30, 30, 31, 2'b01, 2'b10);
      vecs[17] = mk(1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
   end

   // driver: apply one vector per cycle and queue its expectation
   initial begin
      exp_t e;
      int   wait_cyc;
      rst_n = 1'b0;
      ex_we = 1'b0; wb_we = 1'b0;
      r1 = '0; r2 = '0; rd_ex = '0; rd_wb = '0;
      for (int i = 0; i < 18; i++) begin
         @(posedge clk);
         #1;
         rst_n = vecs[i].rst;
         ex_we = vecs[i].exw;
         wb_we = vecs[i].wbw;
         rd_ex = vecs[i].rde;
         rd_wb = vecs[i].rdw;
         r1    = vecs[i].s1;
         r2    = vecs[i].s2;
         e.idx   = i;
         e.ea    = vecs[i].ea;
         e.eb    = vecs[i].eb;
         e.chk_q = (i > 0);
         e.eqa   = 2'b00;
         e.eqb   = 2'b00;
         if (i > 0 && vecs[i-1].rst) begin
            e.eqa = vecs[i-1].ea;
            e.eqb = vecs[i-1].eb;
         end
         sb.push_back(e);
      end
      wait_cyc = 0;
      while (sb.size() > 0 && wait_cyc < 10) begin
         @(posedge clk);
         wait_cyc++;
      end
      if (sb.size() > 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL drain: %0d entries left, required 0",
                  sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   // monitor: compare DUT outputs against the oldest expectation
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            n_chk++;
            if (fa !== e.ea || fb !== e.eb) begin
               n_fail++;
               $display("FAIL comb[%0d]: A=%b B=%b, required A=%b B=%b",
                        e.idx, fa, fb, e.ea, e.eb);
            end
            if (e.chk_q) begin
               n_chk++;
               if (fa_q !== e.eqa || fb_q !== e.eqb) begin
                  n_fail++;
                  $display("FAIL dbgq[%0d]: qA=%b qB=%b, required qA=%b qB=%b",
                           e.idx, fa_q, fb_q, e.eqa, e.eqb);
               end
            end
         end
      end
   end

endmodule

// File: doc/forward_unit.md
Name: forward_unit

Overview:
- Data-hazard forwarding unit for the team's 5-stage RISC-V-style pipeline; sits beside the EX stage.
- Compares the EX-stage source register addresses (Registro1, Registro2) against the destination registers of the two younger-writer stages (EX/MEM "execute" and MEM/WB "writeback").
- Produces 2-bit ALU operand-mux selects forwardA/forwardB combinationally.
- A clocked debug snapshot and optional statistics counters are also included.

Parameters:
- REG_AW, 5, register-address width (32 architectural registers).
- CNT_W, 32, width of statistics counters (only with FWD_STATS_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- Registro1  in  REG_AW  rs1 address of the instruction in EX.
- Registro2  in  REG_AW  rs2 address of the instruction in EX.
- Rd_execute  in  REG_AW  rd of the instruction in EX/MEM.
- Rd_writeback  in  REG_AW  rd of the instruction in MEM/WB.
- ex_regwrite  in  1  EX/MEM instruction writes the register file.
- wb_regwrite  in  1  MEM/WB instruction writes the register file.
- forwardA  out  2  operand-A select (combinational).
- forwardB  out  2  operand-B select (combinational).
- fwd_a_q  out  2  forwardA registered, 1-cycle delayed (debug).
- fwd_b_q  out  2  forwardB registered, 1-cycle delayed (debug).

Behaviour:
- Encoding, shared by forwardA and forwardB:
  - 2'b00: register-file value.
  - 2'b10: forward from EX/MEM.
  - 2'b01: forward from MEM/WB.
  - 2'b11: never produced.
- forwardA (same rule for forwardB using Registro2):
  - 10 if ex_regwrite=1 and Rd_execute≠0 and Rd_execute==Registro1.
  - else 01 if wb_regwrite=1 and Rd_writeback≠0 and Rd_writeback==Registro1.
  - else 00.
- Priority: EX/MEM beats MEM/WB when both match the same source (the newer value wins).
- Register x0: never forwarded. Rd=0 gives 00 regardless of regwrite.
- regwrite=0 blocks forwarding from that stage even when the addresses match.
- A and B are evaluated independently. Both may select the same stage, or different stages, in the same cycle.
- Combinational path:
  - Zero latency; pure function of the current inputs.
  - Does not depend on clk or rst_n, so it is valid during reset.
  - No X propagation on known inputs.
- Registered debug outputs:
  - On each rising clk: if rst_n=0, fwd_a_q/fwd_b_q <= 00; else they take forwardA/forwardB.
  - Reset value 00; reset asserted mid-operation clears them on the next edge.
- No handshakes and no state machine in the base block.

Optional Feature:
- Macro FWD_STATS_EN.
- When defined, adds outputs, each CNT_W wide, clocked, synchronous clear on rst_n=0:
  - cnt_ex_fwd: increments by the number of operands (0, 1 or 2) selecting 10 in the cycle.
  - cnt_wb_fwd: same for selects of 01.
  - cnt_x0_block: increments by 1 when any enabled writer has rd=0 and that rd equals a source register.
- Counters saturate at all-ones and do not wrap.
- When not defined, these ports and registers are absent and the block is otherwise identical.

Decomposition:
- Package forward_pkg:
  - REG_AW default.
  - typedef fwd_sel_t (2-bit enum): FWD_RF=2'b00, FWD_WB=2'b01, FWD_EX=2'b10.
- Sub-module fwd_sel_one: computes one select from (src, rd_ex, ex_we, rd_wb, wb_we). Instantiated twice (A, B).
- The top adds the debug registers and the optional counters.

Test Plan:
- No forwarding: ex_we=0, wb_we=0, Rd_ex=1, Rd_wb=2, R1=3, R2=4 -> A=00, B=00.
- EX→A: ex_we=1, wb_we=0, Rd_ex=3, Rd_wb=2, R1=3, R2=4 -> A=10, B=00.
- WB→A: ex_we=0, wb_we=1, Rd_ex=1, Rd_wb=3, R1=3, R2=4 -> A=01, B=00.
- EX→B: ex_we=1, wb_we=0, Rd_ex=4, Rd_wb=3, R1=3, R2=4 -> A=00, B=10.
- WB→B: ex_we=0, wb_we=1, Rd_ex=1, Rd_wb=4 -> B=01.
- Both stages at once:
  - ex_we=wb_we=1, Rd_ex=4, Rd_wb=3, R1=3, R2=4 -> A=01, B=10.
  - Then Rd_ex=Rd_wb=3 -> A=10 (EX priority).
  - Then Rd_ex=0, R1=0 -> A=00 (x0 rule).
- Reset/debug: hold rst_n=0 for 2 edges -> fwd_a_q=fwd_b_q=00. Release rst_n -> the q outputs track A/B one cycle late.
